// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: register indices, CTRL layout, reset values.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package interval_timer_pkg;

  // Word indices on address[1:0] (bus address[3:2]).
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_COMPARE  = 2'd1;
  localparam logic [1:0] ADDR_COUNT    = 2'd2;
  localparam logic [1:0] ADDR_PRESCALE = 2'd3;

  // CTRL bit positions as seen on the bus.
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IE    = 2;
  localparam int CTRL_MATCH = 8;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Architectural CTRL state, kept compact; expanded to the bus layout on read.
  typedef struct packed {
    logic match;
    logic ie;
    logic auto_rld;
    logic en;
  } ctrl_t;

  // Replace the byte lanes selected by be with the corresponding lanes of wdata.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: free-running pc counts 0..p while enabled and emits tick when pc==p.
// Latency: tick is combinational from pc/p/en; pc updates on the rising edge.
// Backpressure: none; restart has priority over counting.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - count enable; pc holds while low
//   p         - divisor; tick period is p+1 clocks
//   restart   - clear pc to 0 (used when the timer is switched on)
//   tick      - high in the cycle pc==p while enabled
module timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] p,
  input  logic        restart,
  output logic        tick
);

  logic [15:0] pc;

  assign tick = en && (pc == p);

  // If p is lowered below the current pc, pc simply runs on through 0xFFFF
  // and wraps, since only an exact equality produces a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (restart) begin
      pc <= '0;
    end else if (en) begin
      pc <= tick ? 16'd0 : pc + 16'd1;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Memory-mapped 32-bit interval timer with prescaler, compare match, one-shot/auto-reload and level irq.
// Latency: writes visible next cycle; data_out combinational from address; irq one clock after MATCH/IE.
// Backpressure: none; every write strobe is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   read               - decoded read strobe (no side effects, unused internally)
//   write              - decoded single-cycle write strobe
//   address            - word index: 0 CTRL, 1 COMPARE, 2 COUNT, 3 PRESCALE
//   data_in, be        - write data and per-byte enables
//   data_out           - read data for the addressed register
//   irq                - registered level interrupt, MATCH & IE
module interval_timer
  import interval_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  input  logic [3:0]  be,
  output logic [31:0] data_out,
  output logic        irq
);

  ctrl_t       ctrl, ctrl_nxt;
  logic [31:0] compare, compare_nxt;
  logic [31:0] count, count_tick, count_nxt;
  logic [15:0] prescale, prescale_nxt;

  logic wr_ctrl, wr_compare, wr_count, wr_prescale;
  logic tick, hit, restart;

  // Reads have no side effects, so the strobe is intentionally not used.
  logic unused_read;
  assign unused_read = read;

  assign wr_ctrl     = write && (address == ADDR_CTRL);
  assign wr_compare  = write && (address == ADDR_COMPARE);
  assign wr_count    = write && (address == ADDR_COUNT);
  assign wr_prescale = write && (address == ADDR_PRESCALE);

  // Only a genuine 0->1 transition of EN restarts the prescaler phase.
  assign restart = wr_ctrl && be[0] && data_in[CTRL_EN] && !ctrl.en;

  timer_prescaler u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (ctrl.en),
    .p       (prescale),
    .restart (restart),
    .tick    (tick)
  );

  assign hit = tick && (count == compare);

  // Tick update first, then bus bytes on top so a write wins only on its lanes.
  always_comb begin
    count_tick = count;
    if (tick) begin
      if (hit) begin
        if (ctrl.auto_rld) count_tick = '0;
      end else begin
        count_tick = count + 32'd1;
      end
    end
    count_nxt = wr_count ? merge_bytes(count_tick, data_in, be) : count_tick;
  end

  always_comb begin
    compare_nxt = wr_compare ? merge_bytes(compare, data_in, be) : compare;
    prescale_nxt = prescale;
    if (wr_prescale && be[0]) prescale_nxt[7:0]  = data_in[7:0];
    if (wr_prescale && be[1]) prescale_nxt[15:8] = data_in[15:8];
  end

  // Order of assignments encodes the collision priorities: a bus write of EN
  // overrides the one-shot self-disable, and a match set overrides W1C.
  always_comb begin
    ctrl_nxt = ctrl;
    if (hit && !ctrl.auto_rld) ctrl_nxt.en = 1'b0;
    if (wr_ctrl && be[0]) begin
      ctrl_nxt.en       = data_in[CTRL_EN];
      ctrl_nxt.auto_rld = data_in[CTRL_AUTO];
      ctrl_nxt.ie       = data_in[CTRL_IE];
    end
    if (wr_ctrl && be[1] && data_in[CTRL_MATCH]) ctrl_nxt.match = 1'b0;
    if (hit) ctrl_nxt.match = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= '0;
      compare  <= COMPARE_RST;
      count    <= '0;
      prescale <= '0;
      irq      <= 1'b0;
    end else begin
      ctrl     <= ctrl_nxt;
      compare  <= compare_nxt;
      count    <= count_nxt;
      prescale <= prescale_nxt;
      irq      <= ctrl.match && ctrl.ie;
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL:     data_out = {23'd0, ctrl.match, 5'd0, ctrl.ie, ctrl.auto_rld, ctrl.en};
      ADDR_COMPARE:  data_out = compare;
      ADDR_COUNT:    data_out = count;
      ADDR_PRESCALE: data_out = {16'd0, prescale};
      default:       data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench: stimulus pushes expected read responses, a negedge monitor pops and compares.
// Expected values come from a behavioural register-level model or directed constants.
// Random phase mixes writes, reads and occasional resets.
module tb_interval_timer;

  localparam logic [1:0] A_CTRL = 2'd0, A_CMP = 2'd1, A_CNT = 2'd2, A_PS = 2'd3;

  logic        clk;
  logic        rst;
  logic        read;
  logic        write;
  logic [1:0]  address;
  logic [31:0] data_in;
  logic [3:0]  be;
  logic [31:0] data_out;
  logic        irq;

  interval_timer dut (
    .clk      (clk),
    .rst      (rst),
    .read     (read),
    .write    (write),
    .address  (address),
    .data_in  (data_in),
    .be       (be),
    .data_out (data_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  a;
    logic [31:0] d;
    logic        i;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model state (register-level view).
  bit          m_en, m_auto, m_ie, m_match, m_irq;
  logic [31:0] m_cmp, m_cnt, m_p;
  int          m_phase;   // clocks elapsed in the current prescaler period

  function automatic logic [31:0] lane_mask(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      A_CTRL: begin
        v[0] = m_en; v[1] = m_auto; v[2] = m_ie; v[8] = m_match;
      end
      A_CMP: v = m_cmp;
      A_CNT: v = m_cnt;
      default: v = m_p & 32'h0000_FFFF;
    endcase
    return v;
  endfunction

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    bit          tick, hit, was_en, nirq;
    logic [31:0] msk;
    if (rst) begin
      m_en = 0; m_auto = 0; m_ie = 0; m_match = 0; m_irq = 0;
      m_cmp = 32'hFFFF_FFFF; m_cnt = 0; m_p = 0; m_phase = 0;
      return;
    end
    was_en = m_en;
    nirq   = m_match && m_ie;
    tick   = m_en && (m_phase == int'(m_p[15:0]));
    hit    = tick && (m_cnt == m_cmp);
    if (m_en) m_phase = tick ? 0 : (m_phase + 1) % 65536;
    if (tick) begin
      if (!hit)       m_cnt = m_cnt + 1;
      else if (m_auto) m_cnt = 0;
      else             m_en = 0;
    end
    if (write) begin
      msk = lane_mask(be);
      case (address)
        A_CTRL: begin
          if (be[0]) begin
            if (data_in[0] && !was_en) m_phase = 0;
            m_en = data_in[0]; m_auto = data_in[1]; m_ie = data_in[2];
          end
          if (be[1] && data_in[8]) m_match = 0;
        end
        A_CMP: m_cmp = (m_cmp & ~msk) | (data_in & msk);
        A_CNT: m_cnt = (m_cnt & ~msk) | (data_in & msk);
        default: m_p = ((m_p & ~msk) | (data_in & msk)) & 32'h0000_FFFF;
      endcase
    end
    if (hit) m_match = 1;
    m_irq = nirq;
  endtask

  // One bus cycle: model follows the edge, then the next inputs are driven.
  task automatic drv(input logic r, input logic w, input logic rd, input logic [1:0] a,
                     input logic [31:0] d, input logic [3:0] b,
                     input bit cst, input logic [31:0] cd, input logic ci);
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    rst = r; write = w; read = rd; address = a; data_in = d; be = b;
    if (rd) begin
      e.a = a;
      e.d = cst ? cd : model_read(a);
      e.i = cst ? ci : m_irq;
      exp_q.push_back(e);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    drv(1'b0, 1'b1, 1'b0, a, d, b, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rd_c(input logic [1:0] a, input logic [31:0] cd, input logic ci);
    drv(1'b0, 1'b0, 1'b1, a, 32'd0, 4'd0, 1'b1, cd, ci);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      drv(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
  endtask

  // Monitor: every presented read is checked against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (read) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL read_no_expect: addr=%0d data_out=%h irq=%b, no expected entry queued",
                 address, data_out, irq);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e.d || irq !== e.i || address !== e.a) begin
          n_bad++;
          $display("FAIL read_addr%0d @%0t: data_out=%h irq=%b, expected data_out=%h irq=%b",
                   e.a, $time, data_out, irq, e.d, e.i);
        end
      end
    end
  end

  initial begin
    logic        r, w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [3:0]  b;

    rst = 1'b1; read = 1'b0; write = 1'b0; address = 2'd0; data_in = 32'd0; be = 4'd0;
    m_phase = 0;
    drv(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);

    // Reset values.
    rd_c(A_CTRL, 32'd0, 1'b0);
    rd_c(A_CMP, 32'hFFFF_FFFF, 1'b0);
    rd_c(A_CNT, 32'd0, 1'b0);
    rd_c(A_PS, 32'd0, 1'b0);

    // P=3, COMPARE=5, auto-reload with irq: match 24 clocks after the EN edge.
    wr(A_PS, 32'd3, 4'hF);
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CTRL, 32'h7, 4'h1);
    idle(23);
    rd_c(A_CTRL, 32'h007, 1'b0);
    rd_c(A_CTRL, 32'h107, 1'b0);
    rd_c(A_CNT, 32'd0, 1'b1);
    idle(2);
    rd_c(A_CNT, 32'd1, 1'b1);

    // One-shot: P=0, COMPARE=2.
    wr(A_CTRL, 32'h100, 4'h3);
    wr(A_PS, 32'd0, 4'hF);
    wr(A_CMP, 32'd2, 4'hF);
    wr(A_CNT, 32'd0, 4'hF);
    wr(A_CTRL, 32'h5, 4'h1);
    rd_c(A_CNT, 32'd0, 1'b0);
    rd_c(A_CNT, 32'd1, 1'b0);
    rd_c(A_CNT, 32'd2, 1'b0);
    rd_c(A_CTRL, 32'h104, 1'b0);
    rd_c(A_CNT, 32'd2, 1'b1);
    rd_c(A_CTRL, 32'h104, 1'b1);

    // 32-bit wrap of COUNT raises no match.
    wr(A_CTRL, 32'h100, 4'h3);
    wr(A_CMP, 32'd7, 4'hF);
    wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
    wr(A_CTRL, 32'h3, 4'h1);
    rd_c(A_CNT, 32'hFFFF_FFFE, 1'b0);
    rd_c(A_CNT, 32'hFFFF_FFFF, 1'b0);
    rd_c(A_CNT, 32'd0, 1'b0);
    rd_c(A_CNT, 32'd1, 1'b0);
    rd_c(A_CTRL, 32'h003, 1'b0);

    // W1C on the match edge loses; one cycle later it clears and irq follows.
    wr(A_CTRL, 32'h100, 4'h3);
    wr(A_CMP, 32'd2, 4'hF);
    wr(A_CNT, 32'd0, 4'hF);
    wr(A_CTRL, 32'h7, 4'h1);
    idle(2);
    wr(A_CTRL, 32'h100, 4'h2);
    drv(1'b0, 1'b1, 1'b1, A_CTRL, 32'h100, 4'h2, 1'b1, 32'h107, 1'b0);
    rd_c(A_CTRL, 32'h007, 1'b1);
    rd_c(A_CTRL, 32'h007, 1'b0);

    // Byte-lane COUNT write colliding with a tick, then reset mid-run.
    wr(A_CTRL, 32'h100, 4'h3);
    wr(A_CMP, 32'hFFFF_FFFF, 4'hF);
    wr(A_CNT, 32'h0000_AB10, 4'hF);
    wr(A_CTRL, 32'h1, 4'h1);
    wr(A_CNT, 32'h1234_5678, 4'h1);
    rd_c(A_CNT, 32'h0000_AB78, 1'b0);
    drv(1'b1, 1'b1, 1'b0, A_CTRL, 32'h7, 4'hF, 1'b0, 32'd0, 1'b0);
    rd_c(A_CTRL, 32'd0, 1'b0);
    rd_c(A_CMP, 32'hFFFF_FFFF, 1'b0);
    rd_c(A_CNT, 32'd0, 1'b0);
    rd_c(A_PS, 32'd0, 1'b0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 3) == 0);
      a = 2'($urandom_range(0, 3));
      case (a)
        A_CTRL: begin
          d = $urandom & 32'h0000_0107;
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        end
        A_CMP:  d = $urandom_range(0, 15);
        A_CNT:  d = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 15);
        default: d = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
      endcase
      b = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      drv(r, w, 1'b1, a, d, b, 1'b0, 32'd0, 1'b0);
    end

    drv(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected reads left unchecked, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
